decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameters SHALL be: XLEN 36 (scalar data/PC width); NREGS 32 (scalar register count, power of two); IMMW 25 (immediate width); RAW 5 (register address width, clog2(NREGS)).
REQ-002 Ports SHALL be, clock and reset first:
- clk in 1: single clock.
- rst_n in 1: reset, synchronous, active-low.
- in_valid in 1; in_ready out 1: upstream handshake.
- inst in 32; pc_plus_4 in XLEN: instruction and its PC+4.
- ctrl in decode_ctrl_t: imm_type[3:0], rs1, rs2, rd, use_rs1, use_rs2, rd_we, branch_jump, branch_register, branch_type[2:0].
- zero, sign, overflow in 1 each: condition flags.
- wb_en in 1; wb_kill in 1; wb_addr in RAW; wb_data in XLEN: writeback port.
- flush in 1: kills the held instruction.
- out_valid out 1; out_ready in 1: downstream handshake.
- out_sdata1, out_sdata2 out XLEN; out_imm out IMMW; out_rd out RAW; out_rd_we out 1.
- redirect out 1; pc_next out XLEN: branch resolution.

Function
REQ-003 Transfers SHALL occur only when valid and ready are both high in the same cycle; latency is one cycle from input transfer to out_valid.
REQ-004 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-005 hazard SHALL be in_valid && ((use_rs1 && pend[rs1]) || (use_rs2 && pend[rs2])), excluding any source equal to wb_addr with wb_en high in that cycle (bypass).
REQ-006 Register file: NREGS x XLEN, written when wb_en && !wb_kill; register 0 SHALL read as 0 and ignore writes.
REQ-007 A read of wb_addr in the cycle it is written SHALL return wb_data.
REQ-008 Immediates SHALL be extracted by imm_type:
- 0: inst[24:0].
- 1: sext {inst[24:20], inst[15:0]}.
- 2: sext inst[21:0].
- 3: sext inst[14:0].
- 4: sext inst[18:0].
- 5: sext {inst[24:20], inst[9:0]}.
- 6: sext inst[14:4].
- 7: sext {inst[24:20], inst[14:4]}.
- 8: sext {inst[24:20], inst[9:4]}.
- 9-15: 0.
REQ-009 Scoreboard pend[NREGS]: set for rd on input transfer with rd_we && rd!=0; cleared for wb_addr when wb_en or wb_kill is high. Same-register set and clear in one cycle: set wins.
REQ-010 Branch, registered with the output: taken = branch_jump && cond(branch_type, zero, sign, overflow).
- Conditions: 000 always; 001 zero; 010 !zero; 011 sign; 100 !sign; 101 overflow; 110 sign^overflow; 111 never.
- Target: branch_register ? rs1 + sext(imm) : pc_plus_4 + sext(imm), modulo 2^XLEN.
REQ-011 pc_next SHALL be taken ? target : pc_plus_4. redirect SHALL pulse high for exactly the first cycle of out_valid for a taken instruction.
REQ-012 Output fields SHALL hold stable while out_valid && !out_ready.
REQ-013 flush SHALL clear out_valid and redirect next cycle and clear pend[out_rd] if out_rd_we; an in_valid presented in the same cycle SHALL NOT be accepted.

Reset
REQ-014 On rst_n low at a clk edge: out_valid, redirect and all pend bits 0; all registers 0; out_* data fields and pc_next 0.
REQ-015 Reset mid-transfer SHALL discard the held instruction without a downstream handshake.

Configuration
REQ-016 Macro DECODE_WB_BYPASS_EN: when defined, REQ-005 exclusion and REQ-007 forwarding are active. When undefined, a pending source stalls until the cycle after its writeback, and reads return pre-write register contents.

Structure
REQ-017 Package decode_pkg SHALL hold decode_ctrl_t, the IMM_* type codes and the BR_* condition codes.
REQ-018 Scoreboard SHALL be sub-module decode_scoreboard (set/clear/query ports, NREGS parameter); register file inline.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- wb r5=0x123 then decode use_rs1 rs1=5 -> out_sdata1=0x123 one cycle after accept.
- Decode rd=7 rd_we, then rs1=7 -> in_ready 0 until wb_en addr 7; with bypass, accepted in the wb cycle with wb_data.
- imm_type 3, inst[14:0]=0x4000 -> out_imm=0x1FFC000; imm_type 12 -> 0.
- branch_jump, type 001, zero=1, pc_plus_4=0x100, imm=-8 -> redirect 1 for one cycle, pc_next=0xF8; zero=0 -> pc_next=0x100, redirect 0.
- out_ready held 0 for 3 cycles -> outputs stable; flush -> out_valid 0 and pend[rd] cleared.
- Write r0=0xFFF -> reads 0; rst_n low mid-stall -> all pend clear, out_valid 0.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared decode types, immediate/branch codes and helpers
package decode_pkg;

  localparam int DEC_XLEN  = 36;
  localparam int DEC_NREGS = 32;
  localparam int DEC_IMMW  = 25;
  localparam int DEC_RAW   = 5;

  // Immediate layouts (field sources noted per code)
  localparam logic [3:0] IMM_U25  = 4'd0;  // inst[24:0], zero-extended
  localparam logic [3:0] IMM_S21  = 4'd1;  // {inst[24:20], inst[15:0]}
  localparam logic [3:0] IMM_S22  = 4'd2;  // inst[21:0]
  localparam logic [3:0] IMM_S15  = 4'd3;  // inst[14:0]
  localparam logic [3:0] IMM_S19  = 4'd4;  // inst[18:0]
  localparam logic [3:0] IMM_SP15 = 4'd5;  // {inst[24:20], inst[9:0]}
  localparam logic [3:0] IMM_S11  = 4'd6;  // inst[14:4]
  localparam logic [3:0] IMM_SP16 = 4'd7;  // {inst[24:20], inst[14:4]}
  localparam logic [3:0] IMM_SP11 = 4'd8;  // {inst[24:20], inst[9:4]}

  // Branch conditions over the zero/sign/overflow flags
  localparam logic [2:0] BR_ALWAYS = 3'b000;
  localparam logic [2:0] BR_Z      = 3'b001;
  localparam logic [2:0] BR_NZ     = 3'b010;
  localparam logic [2:0] BR_S      = 3'b011;
  localparam logic [2:0] BR_NS     = 3'b100;
  localparam logic [2:0] BR_V      = 3'b101;
  localparam logic [2:0] BR_LT     = 3'b110;
  localparam logic [2:0] BR_NEVER  = 3'b111;

  typedef struct packed {
    logic [3:0]         imm_type;
    logic [DEC_RAW-1:0] rs1;
    logic [DEC_RAW-1:0] rs2;
    logic [DEC_RAW-1:0] rd;
    logic               use_rs1;
    logic               use_rs2;
    logic               rd_we;
    logic               branch_jump;
    logic               branch_register;
    logic [2:0]         branch_type;
  } decode_ctrl_t;

  // Only inst[24:0] carries immediate bits; unknown codes yield zero
  function automatic logic [DEC_IMMW-1:0] imm_extract(input logic [3:0] t, input logic [24:0] i);
    logic [DEC_IMMW-1:0] v;
    case (t)
      IMM_U25:  v = i[24:0];
      IMM_S21:  v = {{4{i[24]}}, i[24:20], i[15:0]};
      IMM_S22:  v = {{3{i[21]}}, i[21:0]};
      IMM_S15:  v = {{10{i[14]}}, i[14:0]};
      IMM_S19:  v = {{6{i[18]}}, i[18:0]};
      IMM_SP15: v = {{10{i[24]}}, i[24:20], i[9:0]};
      IMM_S11:  v = {{14{i[14]}}, i[14:4]};
      IMM_SP16: v = {{9{i[24]}}, i[24:20], i[14:4]};
      IMM_SP11: v = {{14{i[24]}}, i[24:20], i[9:4]};
      default:  v = '0;
    endcase
    return v;
  endfunction

  function automatic logic br_cond(input logic [2:0] bt, input logic z, input logic s, input logic o);
    logic c;
    case (bt)
      BR_ALWAYS: c = 1'b1;
      BR_Z:      c = z;
      BR_NZ:     c = !z;
      BR_S:      c = s;
      BR_NS:     c = !s;
      BR_V:      c = o;
      BR_LT:     c = s ^ o;
      default:   c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// rtl/decode_scoreboard.sv - pending-write scoreboard, one bit per scalar register
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int NREGS = DEC_NREGS,
  parameter int RAW   = DEC_RAW
)(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_set_en,
  input  logic [RAW-1:0] i_set_addr,
  input  logic           i_clr_a_en,
  input  logic [RAW-1:0] i_clr_a_addr,
  input  logic           i_clr_b_en,
  input  logic [RAW-1:0] i_clr_b_addr,
  input  logic [RAW-1:0] i_q1_addr,
  output logic           o_q1_pend,
  input  logic [RAW-1:0] i_q2_addr,
  output logic           o_q2_pend
);

  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pend_next;

  // Apply clears before the set so a fresh claim beats a retiring write to the same register
  always_comb begin
    w_pend_next = r_pend;
    if (i_clr_a_en) w_pend_next[i_clr_a_addr] = 1'b0;
    if (i_clr_b_en) w_pend_next[i_clr_b_addr] = 1'b0;
    if (i_set_en)   w_pend_next[i_set_addr]   = 1'b1;
  end

  // Pending bits, all cleared on reset
  always_ff @(posedge clk) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_next;
  end

  assign o_q1_pend = r_pend[i_q1_addr];
  assign o_q2_pend = r_pend[i_q2_addr];

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - decode stage: regfile read, immediates, hazard stall, branch resolve; option DECODE_WB_BYPASS_EN
module decode_pipe
  import decode_pkg::*;
#(
  parameter int XLEN  = DEC_XLEN,
  parameter int NREGS = DEC_NREGS,
  parameter int IMMW  = DEC_IMMW,
  parameter int RAW   = DEC_RAW
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc_plus_4,
  input  decode_ctrl_t    ctrl,
  input  logic            zero,
  input  logic            sign,
  input  logic            overflow,
  input  logic            wb_en,
  input  logic            wb_kill,
  input  logic [RAW-1:0]  wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_sdata1,
  output logic [XLEN-1:0] out_sdata2,
  output logic [IMMW-1:0] out_imm,
  output logic [RAW-1:0]  out_rd,
  output logic            out_rd_we,
  output logic            redirect,
  output logic [XLEN-1:0] pc_next
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_out_valid, r_redirect, r_out_rd_we;
  logic [XLEN-1:0] r_sdata1, r_sdata2, r_pc_next;
  logic [IMMW-1:0] r_imm;
  logic [RAW-1:0]  r_out_rd;

  logic            w_wb_write, w_byp1, w_byp2, w_pend1, w_pend2;
  logic            w_hazard, w_fire, w_taken, w_set_en, w_clr_a_en, w_clr_b_en;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data, w_imm_sx, w_target;
  logic [IMMW-1:0] w_imm;
  logic            w_unused_inst;

  assign w_unused_inst = ^inst[31:25];

  // Register reads; with the bypass option a same-cycle writeback is forwarded
  always_comb begin
    w_wb_write = wb_en && !wb_kill && (wb_addr != '0);
`ifdef DECODE_WB_BYPASS_EN
    w_byp1     = wb_en && (wb_addr == ctrl.rs1);
    w_byp2     = wb_en && (wb_addr == ctrl.rs2);
    w_rs1_data = (ctrl.rs1 == '0) ? '0 :
                 (w_wb_write && wb_addr == ctrl.rs1) ? wb_data : r_regs[ctrl.rs1];
    w_rs2_data = (ctrl.rs2 == '0) ? '0 :
                 (w_wb_write && wb_addr == ctrl.rs2) ? wb_data : r_regs[ctrl.rs2];
`else
    w_byp1     = 1'b0;
    w_byp2     = 1'b0;
    w_rs1_data = (ctrl.rs1 == '0) ? '0 : r_regs[ctrl.rs1];
    w_rs2_data = (ctrl.rs2 == '0) ? '0 : r_regs[ctrl.rs2];
`endif
  end

  // Stall, handshake, immediate and branch target for the presented instruction
  always_comb begin
    w_hazard   = in_valid && ((ctrl.use_rs1 && w_pend1 && !w_byp1) ||
                              (ctrl.use_rs2 && w_pend2 && !w_byp2));
    in_ready   = (!r_out_valid || out_ready) && !w_hazard && !flush;
    w_fire     = in_valid && in_ready;
    w_imm      = imm_extract(ctrl.imm_type, inst[24:0]);
    w_imm_sx   = {{(XLEN-IMMW){w_imm[IMMW-1]}}, w_imm};
    w_target   = (ctrl.branch_register ? w_rs1_data : pc_plus_4) + w_imm_sx;
    w_taken    = ctrl.branch_jump && br_cond(ctrl.branch_type, zero, sign, overflow);
    w_set_en   = w_fire && ctrl.rd_we && (ctrl.rd != '0);
    w_clr_a_en = wb_en || wb_kill;
    w_clr_b_en = flush && r_out_valid && r_out_rd_we;
  end

  decode_scoreboard #(.NREGS(NREGS), .RAW(RAW)) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_set_en     (w_set_en),
    .i_set_addr   (ctrl.rd),
    .i_clr_a_en   (w_clr_a_en),
    .i_clr_a_addr (wb_addr),
    .i_clr_b_en   (w_clr_b_en),
    .i_clr_b_addr (r_out_rd),
    .i_q1_addr    (ctrl.rs1),
    .o_q1_pend    (w_pend1),
    .i_q2_addr    (ctrl.rs2),
    .o_q2_pend    (w_pend2)
  );

  // Register file write port; r0 is never written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wb_write) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Output stage: flush kills, accept loads, downstream ready drains; redirect lasts one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_redirect  <= 1'b0;
      r_sdata1    <= '0;
      r_sdata2    <= '0;
      r_imm       <= '0;
      r_out_rd    <= '0;
      r_out_rd_we <= 1'b0;
      r_pc_next   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_redirect  <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_redirect  <= w_taken;
      r_sdata1    <= w_rs1_data;
      r_sdata2    <= w_rs2_data;
      r_imm       <= w_imm;
      r_out_rd    <= ctrl.rd;
      r_out_rd_we <= ctrl.rd_we;
      r_pc_next   <= w_taken ? w_target : pc_plus_4;
    end else begin
      if (out_ready) r_out_valid <= 1'b0;
      r_redirect <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign redirect   = r_redirect;
  assign out_sdata1 = r_sdata1;
  assign out_sdata2 = r_sdata2;
  assign out_imm    = r_imm;
  assign out_rd     = r_out_rd;
  assign out_rd_we  = r_out_rd_we;
  assign pc_next    = r_pc_next;

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - self-checking bench for decode_pipe against a behavioural model
module tb_decode_pipe;
  import decode_pkg::*;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, zero, sign, overflow;
  logic        wb_en, wb_kill, flush, out_valid, out_ready, out_rd_we, redirect;
  logic [31:0] inst;
  logic [35:0] pc_plus_4, wb_data, out_sdata1, out_sdata2, pc_next;
  logic [4:0]  wb_addr, out_rd;
  logic [24:0] out_imm;
  decode_ctrl_t ctrl;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  decode_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc_plus_4(pc_plus_4), .ctrl(ctrl),
    .zero(zero), .sign(sign), .overflow(overflow),
    .wb_en(wb_en), .wb_kill(wb_kill), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_sdata1(out_sdata1), .out_sdata2(out_sdata2), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .redirect(redirect), .pc_next(pc_next)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit [35:0] m_regs [32];
  bit        m_pend [32];
  bit        m_ov, m_redir, m_rdwe, m_fresh;
  bit [35:0] m_s1, m_s2, m_pc;
  bit [24:0] m_imm;
  bit [4:0]  m_rd;

  function automatic longint sx(longint v, int w);
    return v[w-1] ? v - (64'sd1 << w) : v;
  endfunction

  function automatic bit [24:0] m_immf(bit [3:0] t, bit [31:0] i);
    longint v;
    case (t)
      0: v = longint'(i[24:0]);
      1: v = sx(longint'({i[24:20], i[15:0]}), 21);
      2: v = sx(longint'(i[21:0]), 22);
      3: v = sx(longint'(i[14:0]), 15);
      4: v = sx(longint'(i[18:0]), 19);
      5: v = sx(longint'({i[24:20], i[9:0]}), 15);
      6: v = sx(longint'(i[14:4]), 11);
      7: v = sx(longint'({i[24:20], i[14:4]}), 16);
      8: v = sx(longint'({i[24:20], i[9:4]}), 11);
      default: v = 0;
    endcase
    return 25'(v);
  endfunction

  function automatic bit m_cond(bit [2:0] bt, bit z, bit s, bit o);
    case (bt)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return s;
      4: return !s;
      5: return o;
      6: return s != o;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [35:0] m_read(bit [4:0] r);
    if (r == 0) return 36'h0;
    if (BYP && wb_en && !wb_kill && wb_addr == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit m_ready();
    bit blk1, blk2;
    blk1 = ctrl.use_rs1 && m_pend[ctrl.rs1] && !(BYP && wb_en && wb_addr == ctrl.rs1);
    blk2 = ctrl.use_rs2 && m_pend[ctrl.rs2] && !(BYP && wb_en && wb_addr == ctrl.rs2);
    return (!m_ov || out_ready) && !(in_valid && (blk1 || blk2)) && !flush;
  endfunction

  task automatic m_step();
    bit fire, tk;
    bit [35:0] a, b;
    bit [24:0] im;
    longint base, tgt;
    fire = in_valid && m_ready();
    a  = m_read(ctrl.rs1);
    b  = m_read(ctrl.rs2);
    im = m_immf(ctrl.imm_type, inst);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
      m_ov = 0; m_redir = 0; m_rdwe = 0; m_s1 = 0; m_s2 = 0; m_pc = 0; m_imm = 0; m_rd = 0;
      m_fresh = 1;
    end else begin
      if (flush) begin
        if (m_ov && m_rdwe) m_pend[m_rd] = 0;
        m_ov = 0; m_redir = 0;
      end
      if (wb_en || wb_kill) m_pend[wb_addr] = 0;
      if (wb_en && !wb_kill && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (fire) begin
        tk   = ctrl.branch_jump && m_cond(ctrl.branch_type, zero, sign, overflow);
        base = ctrl.branch_register ? longint'(a) : longint'(pc_plus_4);
        tgt  = base + sx(longint'(im), 25);
        if (ctrl.rd_we && ctrl.rd != 0) m_pend[ctrl.rd] = 1;
        m_ov = 1; m_redir = tk; m_fresh = 0;
        m_s1 = a; m_s2 = b; m_imm = im; m_rd = ctrl.rd; m_rdwe = ctrl.rd_we;
        m_pc = tk ? 36'(tgt) : pc_plus_4;
      end else if (!flush) begin
        if (out_ready) m_ov = 0;
        m_redir = 0;
      end
    end
  endtask

  always @(posedge clk) m_step();

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(m_ready()));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("redirect", 64'(redirect), 64'(m_redir));
      if (m_ov || m_fresh) begin
        chk("out_sdata1", 64'(out_sdata1), 64'(m_s1));
        chk("out_sdata2", 64'(out_sdata2), 64'(m_s2));
        chk("out_imm", 64'(out_imm), 64'(m_imm));
        chk("out_rd", 64'(out_rd), 64'(m_rd));
        chk("out_rd_we", 64'(out_rd_we), 64'(m_rdwe));
        chk("pc_next", 64'(pc_next), 64'(m_pc));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; wb_en = 0; wb_kill = 0; wb_addr = 0; wb_data = 0; flush = 0;
    ctrl = '0; inst = 0; pc_plus_4 = 0; zero = 0; sign = 0; overflow = 0; out_ready = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit [31:0] pat;
    rst_n = 0;
    idle();
    tick();
    chk_en = 1;
    tick();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_redirect", 64'(redirect), 64'd0);
    chk("rst_pc_next", 64'(pc_next), 64'd0);
    chk("rst_sdata1", 64'(out_sdata1), 64'd0);
    rst_n = 1;

    // S1: write r5 then read it
    tick(); wb_en = 1; wb_addr = 5; wb_data = 36'h123;
    tick(); idle(); in_valid = 1; ctrl.use_rs1 = 1; ctrl.rs1 = 5;
    tick(); in_valid = 0;
    @(negedge clk);
    chk("s1_sdata1", 64'(out_sdata1), 64'h123);
    chk("s1_model_sdata1", 64'(m_s1), 64'h123);

    // S2: RAW hazard on r7 released by writeback
    tick(); idle(); in_valid = 1; ctrl.rd = 7; ctrl.rd_we = 1;
    tick(); ctrl = '0; ctrl.use_rs1 = 1; ctrl.rs1 = 7;
    @(negedge clk); chk("s2_stall_a", 64'(in_ready), 64'd0);
    tick();
    @(negedge clk); chk("s2_stall_b", 64'(in_ready), 64'd0);
    tick(); wb_en = 1; wb_addr = 7; wb_data = 36'h777;
    @(negedge clk); chk("s2_wb_cycle_ready", 64'(in_ready), 64'(BYP));
    tick(); wb_en = 0;
    @(negedge clk); chk("s2_after_wb_ready", 64'(in_ready), 64'd1);
    tick(); in_valid = 0;
    @(negedge clk);
    chk("s2_sdata1", 64'(out_sdata1), 64'h777);
    chk("s2_out_valid", 64'(out_valid), 64'd1);

    // wb_kill clears a pending bit without writing
    tick(); idle(); in_valid = 1; ctrl.rd = 13; ctrl.rd_we = 1;
    tick(); ctrl = '0; in_valid = 0; wb_kill = 1; wb_addr = 13; wb_data = 36'hBAD;
    tick(); idle(); in_valid = 1; ctrl.use_rs1 = 1; ctrl.rs1 = 13;
    @(negedge clk); chk("kill_ready", 64'(in_ready), 64'd1);
    tick(); in_valid = 0;
    @(negedge clk); chk("kill_sdata1", 64'(out_sdata1), 64'd0);

    // S3: immediates
    tick(); idle(); in_valid = 1; ctrl.imm_type = 3; inst = 32'h0000_4000;
    tick(); ctrl.imm_type = 12;
    @(negedge clk);
    chk("s3_imm3", 64'(out_imm), 64'h1FF_C000);
    chk("s3_model_imm3", 64'(m_imm), 64'h1FF_C000);
    tick(); in_valid = 0;
    @(negedge clk); chk("s3_imm12", 64'(out_imm), 64'd0);

    // S4: conditional branch on zero
    tick(); idle(); in_valid = 1; ctrl.branch_jump = 1; ctrl.branch_type = 3'b001;
    ctrl.imm_type = 3; inst = 32'h0000_7FF8; pc_plus_4 = 36'h100; zero = 1; out_ready = 0;
    tick(); in_valid = 0;
    @(negedge clk);
    chk("s4_redirect_first", 64'(redirect), 64'd1);
    chk("s4_pc_taken", 64'(pc_next), 64'hF8);
    chk("s4_model_pc", 64'(m_pc), 64'hF8);
    tick();
    @(negedge clk);
    chk("s4_redirect_second", 64'(redirect), 64'd0);
    chk("s4_held_valid", 64'(out_valid), 64'd1);
    tick(); out_ready = 1; in_valid = 1; zero = 0;
    tick(); in_valid = 0;
    @(negedge clk);
    chk("s4_pc_fall", 64'(pc_next), 64'h100);
    chk("s4_redirect_fall", 64'(redirect), 64'd0);

    // register-based target: r5 (0x123) - 8
    tick(); idle(); in_valid = 1; ctrl.branch_jump = 1; ctrl.branch_register = 1;
    ctrl.rs1 = 5; ctrl.imm_type = 3; inst = 32'h0000_7FF8;
    tick(); in_valid = 0;
    @(negedge clk); chk("s4_reg_target", 64'(pc_next), 64'h11B);

    // target wraps modulo 2^36
    tick(); idle(); in_valid = 1; ctrl.branch_jump = 1; ctrl.imm_type = 3;
    inst = 32'h0000_0020; pc_plus_4 = 36'hF_FFFF_FFF0;
    tick(); in_valid = 0;
    @(negedge clk); chk("s4_wrap", 64'(pc_next), 64'h10);

    // sweep of immediate types, conditions and flags, back to back
    tick(); idle();
    for (int t = 0; t < 16; t++) begin
      pat = 32'h9E37_79B9 * (t + 1);
      in_valid = 1; inst = pat; pc_plus_4 = 36'hF_FFFF_FF00 + 36'(t * 64);
      ctrl = '0; ctrl.imm_type = 4'(t); ctrl.branch_type = 3'(t);
      ctrl.branch_jump = (t != 15); ctrl.branch_register = t[0]; ctrl.rs1 = 5;
      ctrl.rs2 = 5'(t); ctrl.rd = 5'(t);
      {zero, sign, overflow} = 3'(t) ^ 3'b101;
      tick();
    end
    idle();

    // S5: downstream stall then flush
    tick(); idle(); in_valid = 1; ctrl.rd = 9; ctrl.rd_we = 1; inst = 32'h0000_1234;
    pc_plus_4 = 36'h200; out_ready = 0;
    tick(); in_valid = 0;
    repeat (3) begin
      @(negedge clk);
      chk("s5_hold_valid", 64'(out_valid), 64'd1);
      chk("s5_hold_imm", 64'(out_imm), 64'h1234);
      chk("s5_hold_rd", 64'(out_rd), 64'd9);
      chk("s5_hold_pc", 64'(pc_next), 64'h200);
      tick();
    end
    flush = 1; in_valid = 1; ctrl = '0;
    @(negedge clk); chk("s5_flush_blocks", 64'(in_ready), 64'd0);
    tick(); flush = 0; in_valid = 1; ctrl.use_rs1 = 1; ctrl.rs1 = 9; out_ready = 1;
    @(negedge clk);
    chk("s5_flush_valid", 64'(out_valid), 64'd0);
    chk("s5_pend_cleared", 64'(in_ready), 64'd1);
    tick(); in_valid = 0;

    // S6: r0 ignores writes
    tick(); idle(); wb_en = 1; wb_addr = 0; wb_data = 36'hFFF;
    in_valid = 1; ctrl.use_rs1 = 1; ctrl.use_rs2 = 1;
    tick(); wb_en = 0;
    tick(); in_valid = 0;
    @(negedge clk);
    chk("s6_r0_rs1", 64'(out_sdata1), 64'd0);
    chk("s6_r0_rs2", 64'(out_sdata2), 64'd0);

    // S7: reset in the middle of a stall
    tick(); idle(); in_valid = 1; ctrl.rd = 11; ctrl.rd_we = 1; out_ready = 0;
    tick(); ctrl = '0; ctrl.use_rs1 = 1; ctrl.rs1 = 11;
    @(negedge clk); chk("s7_stalled", 64'(in_ready), 64'd0);
    tick(); rst_n = 0; in_valid = 0;
    tick(); rst_n = 1; in_valid = 1; ctrl.use_rs2 = 1; ctrl.rs2 = 5; out_ready = 1;
    @(negedge clk);
    chk("s7_valid_cleared", 64'(out_valid), 64'd0);
    chk("s7_pend_cleared", 64'(in_ready), 64'd1);
    chk("s7_pc_cleared", 64'(pc_next), 64'd0);
    tick(); in_valid = 0;
    @(negedge clk);
    chk("s7_regs_cleared", 64'(out_sdata2), 64'd0);
    chk("s7_new_valid", 64'(out_valid), 64'd1);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
